sha256_block_feeder: RTL and testbench
======================================

# sha256_block_feeder

Upstream stage of the SHA-256 core: on `start`, it reads a byte-sized message from word-addressed memory and performs all SHA-256 padding (delimiter, zero fill, 64-bit bit-length). It hands complete 512-bit blocks to the compression stage over a valid/ready handshake, so the core never handles padding or length arithmetic. Blocks are emitted in order, and the final one is flagged with `blk_last`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a message; sampled only in IDLE
- `message_addr`  in  16  word address of message word 0
- `size`  in  32  message length in bytes; sampled with `start`
- `mem_clk`  out  1  equals `clk`
- `mem_we`  out  1  constant 0
- `mem_addr`  out  16  registered read address
- `mem_read_data`  in  32  read data, valid in the cycle after the memory samples `mem_addr`
- `blk_data`  out  512  padded block; word 0 in [511:480], word 15 in [31:0]
- `blk_valid`  out  1  `blk_data` holds a complete block
- `blk_ready`  in  1  consumer accepts the block
- `blk_last`  out  1  qualifies `blk_valid`; this is the final block of the message
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last block transfers

## Operation
**Start and latching**
- On `start` in IDLE, latch `message_addr` and `size`.
- Compute `nblk = ((size + 8) >> 6) + 1`.
- Compute `nfull = size >> 2`, the number of full message words.
- Clear the block counter `b` and the word counter `w`.

**Word formation**
- Byte order is big-endian: message byte 0 is in [31:24] of word 0.
- Global word index `k = 16*b + w` selects the word content:
  - `k < nfull`: the memory word at `message_addr + k`.
  - `k == nfull`: the delimiter word. Keep the memory bytes `0 .. size%4 - 1` and clear the rest. Place 0x80 in the byte at position `size%4`.
  - When `size%4 == 0`, the delimiter word is 0x80000000 and no memory read is issued for it.
  - Other words: zero.
  - In the last block (`b == nblk - 1`), word 14 is `size >> 29` and word 15 is `size << 3`.
- Length field: 35-bit bit-length `{size, 3'b000}`, zero-extended to 64 bits, split across words 14 and 15.
- Address arithmetic is 16-bit and wraps modulo 2^16.

**State machine**
- IDLE: on `start`, go to GEN.
- GEN: if word `k` needs memory, drive `mem_addr = message_addr + k` and go to WAIT. Otherwise write the computed word, advance `w`, and stay in GEN.
- WAIT: one cycle, then go to CAP.
- CAP: capture `mem_read_data` (masked if it is the delimiter word), advance `w`, and go to GEN.
- After word 15 is written, go to HOLD.
- HOLD: `blk_valid = 1`. On `blk_valid && blk_ready`:
  - not last block: increment `b`, clear `w`, go to GEN;
  - last block: go to DONE.
- DONE: `done = 1` for one cycle, then go to IDLE.

**Edge cases**
- `start` outside IDLE is ignored.
- `size` and `message_addr` changes outside IDLE have no effect.
- Reset at any point aborts immediately. All outputs take their reset values and no partial block is ever presented.

## Timing
- Reset values: `mem_addr` 0, `mem_we` 0, `blk_data` 0, `blk_valid` 0, `blk_last` 0, `busy` 0, `done` 0; state IDLE.
- Cycle cost:
  - a memory word takes 3 cycles (GEN, WAIT, CAP);
  - a generated word takes 1 cycle.
- Latency:
  - a block of 16 memory words: `blk_valid` rises 48 cycles after entering GEN;
  - an all-generated block: 16 cycles.
- While `blk_valid` is high, `blk_data` and `blk_last` are stable. They change only after the handshake edge.
- `blk_valid` drops in the cycle after the handshake edge. There are no back-to-back blocks: the next block needs at least 16 cycles.
- `blk_ready` is ignored when `blk_valid` is 0.
- `done` asserts in the cycle after the handshake on the last block.
- `busy` falls together with the DONE→IDLE transition.

## Test plan
- **Single-block message:** `size` = 3, memory word 0x61626300 → one block. Word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018, `blk_last` = 1, then `done` pulses once.
- **Empty message:** `size` = 0 → one block. Word 0 = 0x80000000, all other words 0, and no memory reads (`mem_addr` never changes).
- **Delimiter spills to a second block:** `size` = 56 → two blocks.
  - Block 0: words 0–13 from memory, word 14 = 0x80000000, word 15 = 0, `blk_last` = 0.
  - Block 1: words 0–14 = 0, word 15 = 0x000001C0, `blk_last` = 1.
- **Exact multiple of 64:** `size` = 64 → block 0 reads 16 words at `message_addr`..`message_addr + 15`. Block 1 has word 0 = 0x80000000 and word 15 = 0x00000200.
- **Backpressure:** hold `blk_ready` = 0 for 10 cycles with `blk_valid` high → `blk_data` is unchanged every cycle. Raise `blk_ready` for one cycle → exactly one transfer, and `blk_valid` falls the next cycle.
- **Reset mid-fill:** pulse `reset_n` low during WAIT of word 5 → all outputs return to reset values immediately. A new `start` with `size` = 3 then produces the correct single block.

Source files
------------

// File: rtl/sha256_block_feeder_if.sv
// Memory read port and padded-block handshake between the block feeder and its neighbours.
interface sha256_block_feeder_if;
  logic         mem_clk;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_read_data;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_last;

  modport master (
    output mem_clk, mem_we, mem_addr, blk_data, blk_valid, blk_last,
    input  mem_read_data, blk_ready
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr, blk_data, blk_valid, blk_last,
    output mem_read_data, blk_ready
  );
endinterface

// File: rtl/sha256_block_feeder.sv
// Reads a byte message from word memory, applies SHA-256 padding and
// emits 512-bit blocks in order over a valid/ready handshake.
module sha256_block_feeder (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            message_addr,
  input  logic [31:0]            size,
  output logic                   busy,
  output logic                   done,
  sha256_block_feeder_if.master  bus
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 27;
  localparam int unsigned K_W    = BLK_W + 4;
  localparam int unsigned DATA_W = 16 * WORD_W;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] GEN  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] CAP  = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [WORD_W-1:0] len, len_nxt;
  logic [BLK_W-1:0]  nblk, nblk_nxt;
  logic [BLK_W-1:0]  b, b_nxt;
  logic [3:0]        w, w_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              valid_q, valid_nxt;
  logic              last_q, last_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;

  logic [K_W-1:0]    k;
  logic [K_W-1:0]    nfull;
  logic              is_last, is_delim, len_word, need_mem;
  logic [WORD_W-1:0] gen_word, cap_word, word;
  logic              wr;

  // Global word index within the padded message.
  assign k        = {b, w};
  assign nfull    = K_W'(len[31:2]);
  assign is_last  = (b == nblk - BLK_W'(1));
  assign len_word = is_last && (w >= 4'd14);
  assign is_delim = (k == nfull);
  assign need_mem = !len_word && ((k < nfull) || (is_delim && (len[1:0] != 2'b00)));

  always_comb begin
    gen_word = '0;
    if (len_word) begin
      gen_word = w[0] ? {len[28:0], 3'b000} : {29'b0, len[31:29]};
    end else if (is_delim) begin
      gen_word = 32'h8000_0000;
    end
  end

  // Delimiter word keeps the leading message bytes and inserts 0x80 after them.
  always_comb begin
    cap_word = bus.mem_read_data;
    if (is_delim) begin
      case (len[1:0])
        2'd1:    cap_word = {bus.mem_read_data[31:24], 24'h80_0000};
        2'd2:    cap_word = {bus.mem_read_data[31:16], 16'h8000};
        2'd3:    cap_word = {bus.mem_read_data[31:8],  8'h80};
        default: cap_word = bus.mem_read_data;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    len_nxt      = len;
    nblk_nxt     = nblk;
    b_nxt        = b;
    w_nxt        = w;
    mem_addr_nxt = mem_addr_q;
    data_nxt     = data_q;
    valid_nxt    = valid_q;
    last_nxt     = last_q;
    done_nxt     = 1'b0;
    word         = '0;
    wr           = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          base_nxt  = message_addr;
          len_nxt   = size;
          nblk_nxt  = BLK_W'((33'(size) + 33'd8) >> 6) + BLK_W'(1);
          b_nxt     = '0;
          w_nxt     = '0;
          state_nxt = GEN;
        end
      end
      GEN: begin
        if (need_mem) begin
          mem_addr_nxt = base + ADDR_W'(k);
          state_nxt    = WAIT;
        end else begin
          word = gen_word;
          wr   = 1'b1;
        end
      end
      WAIT: state_nxt = CAP;
      CAP: begin
        word = cap_word;
        wr   = 1'b1;
      end
      HOLD: begin
        if (bus.blk_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          if (is_last) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            b_nxt     = b + BLK_W'(1);
            w_nxt     = '0;
            state_nxt = GEN;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Shift the new word in; word 0 ends up in the top slot after 16 writes.
    if (wr) begin
      data_nxt = {data_q[DATA_W-WORD_W-1:0], word};
      if (w == 4'd15) begin
        valid_nxt = 1'b1;
        last_nxt  = is_last;
        state_nxt = HOLD;
      end else begin
        w_nxt     = w + 4'd1;
        state_nxt = GEN;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      base       <= '0;
      len        <= '0;
      nblk       <= '0;
      b          <= '0;
      w          <= '0;
      mem_addr_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      len        <= len_nxt;
      nblk       <= nblk_nxt;
      b          <= b_nxt;
      w          <= w_nxt;
      mem_addr_q <= mem_addr_nxt;
      data_q     <= data_nxt;
      valid_q    <= valid_nxt;
      last_q     <= last_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
    end
  end

  assign bus.mem_clk   = clk;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.blk_data  = data_q;
  assign bus.blk_valid = valid_q;
  assign bus.blk_last  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_sha256_block_feeder.sv
// Bench for sha256_block_feeder: byte-level SHA-256 padding model, block timing and read-address log.
module tb_sha256_block_feeder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] message_addr = '0;
  logic [31:0] size = '0;
  logic        busy, done;

  sha256_block_feeder_if bus();

  sha256_block_feeder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .message_addr (message_addr),
    .size         (size),
    .busy         (busy),
    .done         (done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge bus.mem_clk) bus.mem_read_data <= mem[bus.mem_addr];

  int total = 0;
  int bad = 0;
  int cyc;
  logic [15:0]  addr_log[$];
  logic [15:0]  last_addr;
  logic [511:0] exp_blk[$];
  int           exp_cost[$];
  logic [511:0] obs_blk[$];

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.mem_addr !== last_addr) begin
      addr_log.push_back(bus.mem_addr);
      last_addr = bus.mem_addr;
    end
  endtask

  task automatic fill_mem(input logic [15:0] a, input int unsigned n);
    for (int i = 0; i < int'(n); i++) mem[a + 16'(i)] = $urandom;
  endtask

  // Padded message built byte by byte, then cut into 64-byte blocks.
  task automatic build_model(input logic [15:0] a, input int unsigned sz);
    logic [7:0]   bq[$];
    logic [31:0]  wv;
    logic [63:0]  bitlen;
    logic [511:0] blk;
    int           reads, m;
    exp_blk.delete();
    exp_cost.delete();
    for (int i = 0; i < int'(sz); i++) begin
      wv = mem[a + 16'(i / 4)];
      bq.push_back(wv[31 - 8 * (i % 4) -: 8]);
    end
    bq.push_back(8'h80);
    while ((bq.size() % 64) != 56) bq.push_back(8'h00);
    bitlen = {29'b0, sz, 3'b000};
    for (int j = 7; j >= 0; j--) bq.push_back(bitlen[8 * j +: 8]);
    reads = int'((sz + 3) / 4);
    for (int bi = 0; bi < bq.size() / 64; bi++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk = {blk[503:0], bq[64 * bi + i]};
      exp_blk.push_back(blk);
      m = 0;
      for (int kk = 16 * bi; kk < 16 * bi + 16; kk++) if (kk < reads) m++;
      exp_cost.push_back(16 + 2 * m);
    end
  endtask

  task automatic run_msg(input logic [15:0] a, input int unsigned sz,
                         input int hold_min, input int hold_max, input bit scramble);
    logic [15:0] pre;
    logic [15:0] exp_reads[$];
    int          nb, hold;
    build_model(a, sz);
    obs_blk.delete();
    nb = exp_blk.size();
    @(negedge clk);
    start = 1'b1; message_addr = a; size = sz;
    pre = bus.mem_addr; last_addr = pre; addr_log.delete();
    tick();
    start = 1'b0;
    if (scramble) begin message_addr = 16'($urandom); size = $urandom; end
    cyc = 0;
    for (int j = 0; j < nb; j++) begin
      while (bus.blk_valid !== 1'b1 && cyc < 3000) begin
        tick();
        start         = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.blk_ready = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start = 1'b0; bus.blk_ready = 1'b0;
      total++;
      if (bus.blk_valid !== 1'b1) begin
        bad++; $display("FAIL timeout blk %0d size=%0d: blk_valid never rose", j, sz);
        return;
      end
      obs_blk.push_back(bus.blk_data);
      total++;
      if (cyc !== exp_cost[j]) begin bad++; $display("FAIL latency blk %0d size=%0d: got %0d cycles, want %0d", j, sz, cyc, exp_cost[j]); end
      total++;
      if (bus.blk_data !== exp_blk[j]) begin bad++; $display("FAIL data blk %0d size=%0d: got %h want %h", j, sz, bus.blk_data, exp_blk[j]); end
      total++;
      if (bus.blk_last !== (j == nb - 1)) begin bad++; $display("FAIL last blk %0d size=%0d: got %b want %b", j, sz, bus.blk_last, j == nb - 1); end
      total++;
      if (busy !== 1'b1 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL busy/we blk %0d: busy=%b we=%b want 1/0", j, busy, bus.mem_we); end
      hold = $urandom_range(hold_min, hold_max);
      for (int h = 0; h < hold; h++) begin
        tick();
        total++;
        if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp_blk[j] || bus.blk_last !== (j == nb - 1)) begin
          bad++; $display("FAIL stall blk %0d cycle %0d: valid=%b last=%b data=%h", j, h, bus.blk_valid, bus.blk_last, bus.blk_data);
        end
      end
      bus.blk_ready = 1'b1;
      tick();
      bus.blk_ready = 1'b0;
      total++;
      if (bus.blk_valid !== 1'b0) begin bad++; $display("FAIL valid_drop blk %0d: got %b want 0", j, bus.blk_valid); end
      if (j == nb - 1) begin
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL done_pulse size=%0d: got %b want 1", sz, done); end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_end size=%0d: done=%b busy=%b want 0/0", sz, done, busy); end
      end else begin
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL early_done blk %0d: got %b want 0", j, done); end
        cyc = 0;
      end
    end
    for (int i = 0; i < int'((sz + 3) / 4); i++)
      if (!(i == 0 && (a + 16'(i)) == pre)) exp_reads.push_back(a + 16'(i));
    total++;
    if (addr_log.size() != exp_reads.size()) begin
      bad++; $display("FAIL read_count size=%0d: got %0d addr changes want %0d", sz, addr_log.size(), exp_reads.size());
    end else begin
      for (int i = 0; i < exp_reads.size(); i++) begin
        total++;
        if (addr_log[i] !== exp_reads[i]) begin bad++; $display("FAIL read_addr %0d: got %h want %h", i, addr_log[i], exp_reads[i]); end
      end
    end
  endtask

  task automatic test_reset();
    bus.blk_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.mem_addr !== 16'h0 || bus.mem_we !== 1'b0 || bus.blk_data !== '0 || bus.blk_valid !== 1'b0 ||
        bus.blk_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_values: addr=%h we=%b valid=%b last=%b busy=%b done=%b", bus.mem_addr, bus.mem_we, bus.blk_valid, bus.blk_last, busy, done);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    mem[16'h1234] = 32'h6162_6300;
    run_msg(16'h1234, 3, 0, 2, 1'b0);
    total++;
    if (obs_blk.size() != 1 || obs_blk[0] !== {32'h6162_6380, 448'h0, 32'h0000_0018}) begin
      bad++; $display("FAIL abc_block: got %0d blocks, blk0=%h", obs_blk.size(), obs_blk[0]);
    end
  endtask

  task automatic test_empty();
    run_msg(16'h0777, 0, 0, 2, 1'b0);
    total++;
    if (obs_blk.size() != 1 || obs_blk[0] !== {32'h8000_0000, 480'h0}) begin
      bad++; $display("FAIL empty_block: got %0d blocks, blk0=%h", obs_blk.size(), obs_blk[0]);
    end
    total++;
    if (addr_log.size() != 0) begin bad++; $display("FAIL empty_reads: got %0d addr changes want 0", addr_log.size()); end
  endtask

  task automatic test_spill();
    fill_mem(16'h2000, 14);
    run_msg(16'h2000, 56, 0, 2, 1'b0);
    total++;
    if (obs_blk.size() != 2 || obs_blk[0][63:0] !== 64'h8000_0000_0000_0000 || obs_blk[1] !== {480'h0, 32'h0000_01C0}) begin
      bad++; $display("FAIL spill: got %0d blocks, blk0 tail=%h blk1=%h", obs_blk.size(), obs_blk[0][63:0], obs_blk[1]);
    end
  endtask

  task automatic test_multiple64();
    fill_mem(16'hFFF8, 16);
    run_msg(16'hFFF8, 64, 0, 2, 1'b0);
    total++;
    if (obs_blk.size() != 2 || obs_blk[1] !== {32'h8000_0000, 448'h0, 32'h0000_0200}) begin
      bad++; $display("FAIL mult64: got %0d blocks, blk1=%h", obs_blk.size(), obs_blk[1]);
    end
  endtask

  task automatic test_backpressure();
    fill_mem(16'h0400, 30);
    run_msg(16'h0400, 117, 10, 10, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] a;
    a = 16'h5A00;
    fill_mem(a, 16);
    @(negedge clk);
    start = 1'b1; message_addr = a; size = 64;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    total++;
    if (bus.mem_addr !== a + 16'd5 || busy !== 1'b1 || bus.blk_valid !== 1'b0) begin
      bad++; $display("FAIL pre_reset: addr=%h want %h busy=%b valid=%b", bus.mem_addr, a + 16'd5, busy, bus.blk_valid);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.mem_addr !== 16'h0 || bus.blk_data !== '0 || bus.blk_valid !== 1'b0 || bus.blk_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL async_reset: addr=%h valid=%b last=%b busy=%b done=%b", bus.mem_addr, bus.blk_valid, bus.blk_last, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mem[16'h0010] = 32'h6162_6300;
    run_msg(16'h0010, 3, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    int unsigned sz;
    for (int it = 0; it < 8; it++) begin
      sz = $urandom_range(0, 300);
      a  = (it % 3 == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      fill_mem(a, (sz + 3) / 4 + 1);
      run_msg(a, sz, 0, 3, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_empty();
    test_spill();
    test_multiple64();
    test_backpressure();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
